// File: rtl/mem_arb_pkg.sv
// Shared constants for the IF/D memory arbiter: FSM encoding, master ids, strobe width.
// All arbiter RTL and the interface import this package.
package mem_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

    localparam logic MASTER_IF = 1'b0;
    localparam logic MASTER_D  = 1'b1;

    // MEM_LAT is at most 8, so MEM_LAT-1 fits in three bits.
    localparam int LAT_W = 3;

    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the fetch port, load/store port and memory port seen by the arbiter.
// slave is the arbiter's view; master is the core+memory environment's view.
interface mem_bus_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = strb_w(DATA_W);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [STRB_W-1:0] d_wstrb;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_ack, if_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_ack, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_ack, if_rdata,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_ack, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata
    );

endinterface

// File: rtl/arb_pick.sv
// Winner select between fetch and data with a starvation counter for fetch.
// Combinational pick; starve_cnt updates only on the cycle a grant is taken.
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
)(
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic d_req,
    input  logic grant_en,
    output logic winner,
    output logic valid
);
    localparam int CNT_W = $clog2(STARVE_MAX + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    logic             if_forced;

    assign if_forced = if_req && (starve_cnt == CNT_MAX);

    always_comb begin
        valid  = if_req | d_req;
        winner = MASTER_IF;
        if (d_req && !if_forced) begin
            winner = MASTER_D;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (grant_en && valid) begin
            if (winner == MASTER_IF) begin
                starve_cnt <= '0;
            end else if (if_req && (starve_cnt != CNT_MAX)) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises IF and D accesses onto one single-port memory; ack arrives 2+MEM_LAT cycles after grant.
// Requesters hold req until ack; one access in flight, new grants only from IDLE.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
)(
    input  logic             clk,
    input  logic             rst,
    mem_bus_arbiter_if.slave bus,
    output logic             busy
);
    localparam int STRB_W = strb_w(DATA_W);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

    state_t           state;
    logic             win_id;
    logic             win_we;
    logic [LAT_W-1:0] lat_cnt;

    logic             grant_en;
    logic             pick_id;
    logic             pick_vld;

    assign grant_en = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

    arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk      (clk),
        .rst      (rst),
        .if_req   (bus.if_req),
        .d_req    (bus.d_req),
        .grant_en (grant_en),
        .winner   (pick_id),
        .valid    (pick_vld)
    );

    // mem_* are registers loaded at grant, so the requester's attributes are
    // frozen for the whole access and nothing combinational reaches the memory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            win_id        <= MASTER_IF;
            win_we        <= 1'b0;
            lat_cnt       <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_wstrb <= '0;
            bus.if_ack    <= 1'b0;
            bus.d_ack     <= 1'b0;
            bus.if_rdata  <= '0;
            bus.d_rdata   <= '0;
        end else begin
            bus.if_ack <= 1'b0;
            bus.d_ack  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        state      <= ST_ISSUE;
                        win_id     <= pick_id;
                        bus.mem_en <= 1'b1;
                        if (pick_id == MASTER_D) begin
                            win_we        <= bus.d_we;
                            bus.mem_we    <= bus.d_we;
                            bus.mem_addr  <= bus.d_addr;
                            bus.mem_wdata <= bus.d_wdata;
                            bus.mem_wstrb <= bus.d_we ? bus.d_wstrb : {STRB_W{1'b0}};
                        end else begin
                            win_we        <= 1'b0;
                            bus.mem_we    <= 1'b0;
                            bus.mem_addr  <= bus.if_addr;
                            bus.mem_wdata <= '0;
                            bus.mem_wstrb <= '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    bus.mem_en    <= 1'b0;
                    bus.mem_we    <= 1'b0;
                    bus.mem_wstrb <= '0;
                    lat_cnt       <= LAT_LOAD;
                    state         <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end else begin
                        state <= ST_RESP;
                        if (win_id == MASTER_D) begin
                            bus.d_ack <= 1'b1;
                            if (!win_we) begin
                                bus.d_rdata <= bus.mem_rdata;
                            end
                        end else begin
                            bus.if_ack   <= 1'b1;
                            bus.if_rdata <= bus.mem_rdata;
                        end
                    end
                end
                ST_RESP: begin
                    // Requester still holds req here; it is not looked at until IDLE.
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3) with behavioural memories.
// Expected acks are queued at issue time and checked by a separate negedge monitor.
module tb_mem_bus_arbiter;

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst1, rst3;
    logic busy1, busy3;
    int   cyc;
    int   n_tests;
    int   n_fail;

    exp_t q1[$];
    exp_t q3[$];

    logic [31:0] mem1 [0:255];
    logic [31:0] mem3 [0:255];
    logic [31:0] p3a, p3b;

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1();
    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3();

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
        .clk  (clk),
        .rst  (rst1),
        .bus  (b1.slave),
        .busy (busy1)
    );

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
        .clk  (clk),
        .rst  (rst3),
        .bus  (b3.slave),
        .busy (busy3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory with one cycle latency; rdata is junk except in the cycle after mem_en.
    always @(posedge clk) begin
        if (!rst1) begin
            for (int i = 0; i < 256; i++) mem1[i] <= 32'hC0DE_0000 | 32'(i);
            mem1[0]      <= 32'h0000_0013;
            b1.mem_rdata <= '0;
        end else begin
            b1.mem_rdata <= 32'hBAD1_BAD1;
            if (b1.mem_en) begin
                b1.mem_rdata <= mem1[b1.mem_addr[9:2]];
                if (b1.mem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (b1.mem_wstrb[b]) mem1[b1.mem_addr[9:2]][8*b +: 8] <= b1.mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Memory with three cycle latency; data appears only in cycle mem_en+3.
    always @(posedge clk) begin
        if (!rst3) begin
            for (int i = 0; i < 256; i++) mem3[i] <= 32'hC0DE_0000 | 32'(i);
            mem3[16]     <= 32'h55AA_55AA;
            p3a          <= '0;
            p3b          <= '0;
            b3.mem_rdata <= '0;
        end else begin
            p3a          <= b3.mem_en ? mem3[b3.mem_addr[9:2]] : 32'hBAD3_BAD3;
            p3b          <= p3a;
            b3.mem_rdata <= p3b;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out at cycle %0d", nm, cyc);
    endtask

    task automatic score(input int id, input logic ia, input logic da,
                         input logic [31:0] ir, input logic [31:0] dr);
        exp_t e;
        bit   empty;
        check($sformatf("ack_overlap%0d", id), {31'b0, ia & da}, 32'd0);
        empty = (id == 1) ? (q1.size() == 0) : (q3.size() == 0);
        if (empty) begin
            check($sformatf("unexpected_ack%0d", id), {30'b0, ia, da}, 32'd0);
        end else begin
            if (id == 1) e = q1.pop_front();
            else         e = q3.pop_front();
            check($sformatf("ack_master%0d", id), {31'b0, da}, {31'b0, e.is_d});
            check($sformatf("ack_cycle%0d", id), cyc, e.cyc);
            check($sformatf("ack_rdata%0d", id), da ? dr : ir, e.rdata);
        end
    endtask

    always @(negedge clk) begin
        if (b1.if_ack || b1.d_ack) score(1, b1.if_ack, b1.d_ack, b1.if_rdata, b1.d_rdata);
        if (b3.if_ack || b3.d_ack) score(3, b3.if_ack, b3.d_ack, b3.if_rdata, b3.d_rdata);
    end

    task automatic wait_idle1();
        int n = 0;
        @(negedge clk);
        while (busy1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy1) fail_now("idle1");
    endtask

    // One access on the MEM_LAT=1 instance; attributes are scrambled after grant.
    task automatic acc1(input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        input logic [31:0] exp_rd);
        int  k;
        int  n;
        bit  got;
        exp_t e;
        wait_idle1();
        k = cyc;
        if (is_d) begin
            b1.d_req = 1'b1; b1.d_we = we; b1.d_addr = addr; b1.d_wdata = wdata; b1.d_wstrb = wstrb;
        end else begin
            b1.if_req = 1'b1; b1.if_addr = addr;
        end
        e.is_d = is_d; e.rdata = exp_rd; e.cyc = k + 3;
        q1.push_back(e);
        @(negedge clk);
        check("issue_mem_en", {31'b0, b1.mem_en}, 32'd1);
        check("issue_mem_we", {31'b0, b1.mem_we}, {31'b0, is_d & we});
        check("issue_mem_wstrb", {28'b0, b1.mem_wstrb}, (is_d && we) ? {28'b0, wstrb} : 32'd0);
        check("issue_mem_addr", b1.mem_addr, addr);
        if (is_d && we) check("issue_mem_wdata", b1.mem_wdata, wdata);
        check("issue_busy", {31'b0, busy1}, 32'd1);
        b1.if_addr = ~addr; b1.d_addr = ~addr; b1.d_wdata = ~wdata; b1.d_we = ~we;
        @(negedge clk);
        check("wait_mem_en", {31'b0, b1.mem_en}, 32'd0);
        check("wait_busy", {31'b0, busy1}, 32'd1);
        got = 1'b0;
        n = 0;
        while (!got && n < 12) begin
            @(negedge clk);
            got = is_d ? b1.d_ack : b1.if_ack;
            n++;
        end
        if (!got) fail_now("ack1");
        else check("resp_busy", {31'b0, busy1}, 32'd1);
        b1.if_req = 1'b0;
        b1.d_req  = 1'b0;
    endtask

    initial begin
        int   k;
        int   n;
        exp_t e;
        cyc = 0; n_tests = 0; n_fail = 0;
        rst1 = 1'b1; rst3 = 1'b1;
        b1.if_req = 0; b1.if_addr = 0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = 0; b1.d_wdata = 0; b1.d_wstrb = 0;
        b3.if_req = 0; b3.if_addr = 0; b3.d_req = 0; b3.d_we = 0; b3.d_addr = 0; b3.d_wdata = 0; b3.d_wstrb = 0;
        #1;
        rst1 = 1'b0; rst3 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy1", {31'b0, busy1}, 32'd0);
        check("rst_mem1", {b1.mem_en, b1.mem_we, b1.mem_wstrb, b1.mem_addr[25:0]}, 32'd0);
        check("rst_rdata1", b1.if_rdata | b1.d_rdata | b1.mem_wdata, 32'd0);
        check("rst_ack1", {30'b0, b1.if_ack, b1.d_ack}, 32'd0);
        check("rst_busy3", {31'b0, busy3}, 32'd0);
        check("rst_rdata3", b3.if_rdata | b3.d_rdata, 32'd0);
        rst1 = 1'b1; rst3 = 1'b1;

        // Directed single-requester vectors: {is_d, we, addr, wdata, wstrb, expected rdata}.
        acc1(0, 0, 32'h0000_0000, 32'h0,         4'h0, 32'h0000_0013);
        acc1(1, 1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000);
        check("if_rdata_hold", b1.if_rdata, 32'h0000_0013);
        acc1(1, 0, 32'h0000_0100, 32'h0,         4'h0, 32'hDEAD_BEEF);
        acc1(1, 1, 32'h0000_0100, 32'h1122_3344, 4'h5, 32'hDEAD_BEEF);
        acc1(1, 0, 32'h0000_0100, 32'h0,         4'h0, 32'hDE22_BE44);
        acc1(1, 1, 32'h0000_0104, 32'hFFFF_FFFF, 4'h0, 32'hDE22_BE44);
        acc1(1, 0, 32'h0000_0104, 32'h0,         4'h0, 32'hC0DE_0041);
        acc1(0, 0, 32'h0000_0008, 32'h0,         4'h0, 32'hC0DE_0002);

        // Both requesters held: D four times, then IF forced, repeated.
        wait_idle1();
        k = cyc;
        b1.if_req = 1'b1; b1.if_addr = 32'h4;
        b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 32'h200;
        for (int i = 0; i < 10; i++) begin
            e.is_d  = !(i == 4 || i == 9);
            e.rdata = e.is_d ? 32'hC0DE_0080 : 32'hC0DE_0001;
            e.cyc   = k + 3 + 4 * i;
            q1.push_back(e);
        end
        n = 0;
        while (q1.size() != 0 && n < 80) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (q1.size() != 0) fail_now("starve_drain");
        b1.if_req = 1'b0; b1.d_req = 1'b0;

        // Reset during WAIT: access dropped, held if_req is granted afresh.
        wait_idle1();
        k = cyc;
        b1.if_req = 1'b1; b1.if_addr = 32'hC;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", {31'b0, busy1}, 32'd1);
        #2 rst1 = 1'b0;
        #1;
        check("arst_busy", {31'b0, busy1}, 32'd0);
        check("arst_mem", {b1.mem_en, b1.mem_we, b1.mem_wstrb, b1.mem_addr[25:0]}, 32'd0);
        check("arst_rdata", b1.if_rdata | b1.d_rdata, 32'd0);
        @(negedge clk);
        check("in_rst_mem_en", {31'b0, b1.mem_en}, 32'd0);
        #2 rst1 = 1'b1;
        e.is_d = 1'b0; e.rdata = 32'hC0DE_0003; e.cyc = k + 6;
        q1.push_back(e);
        @(negedge clk);
        check("post_rst_mem_en", {31'b0, b1.mem_en}, 32'd1);
        check("post_rst_addr", b1.mem_addr, 32'hC);
        n = 0;
        while (!b1.if_ack && n < 12) begin
            @(negedge clk);
            n++;
        end
        if (!b1.if_ack) fail_now("post_rst_ack");
        b1.if_req = 1'b0;

        // MEM_LAT=3 D read.
        @(negedge clk);
        check("lat3_idle", {31'b0, busy3}, 32'd0);
        k = cyc;
        b3.d_req = 1'b1; b3.d_we = 1'b0; b3.d_addr = 32'h40;
        e.is_d = 1'b1; e.rdata = 32'h55AA_55AA; e.cyc = k + 5;
        q3.push_back(e);
        @(negedge clk);
        check("lat3_mem_en", {31'b0, b3.mem_en}, 32'd1);
        check("lat3_addr", b3.mem_addr, 32'h40);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("lat3_wait", {30'b0, b3.mem_en, b3.d_ack}, 32'd0);
        end
        n = 0;
        while (!b3.d_ack && n < 12) begin
            @(negedge clk);
            n++;
        end
        if (!b3.d_ack) fail_now("lat3_ack");
        b3.d_req = 1'b0;

        repeat (4) @(negedge clk);
        check("q1_drain", q1.size(), 32'd0);
        check("q3_drain", q3.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
